// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// forward-select codes and the hard-wired zero register.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Youngest producer wins; register 0 is never a real producer.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic [4:0] mem_rd,
      input logic       mem_regwr,
      input logic [4:0] wb_rd,
      input logic       wb_regwr
   );
      if (mem_regwr && mem_rd != REG_ZERO && mem_rd == src)
         return FWD_EXMEM;
      else if (wb_regwr && wb_rd != REG_ZERO && wb_rd == src)
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational EX operand forwarding selects; operand A from ex_rs,
// operand B from ex_rt, each resolved independently.
module forward_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic [4:0] mem_rd,
   input  logic       mem_regwr,
   input  logic [4:0] wb_rd,
   input  logic       wb_regwr,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   localparam int NUM_SRC = 2;

   logic [NUM_SRC-1:0][4:0] src;
   logic [NUM_SRC-1:0][1:0] sel;

   assign src = {ex_rt, ex_rs};

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign sel[g] = fwd_sel(src[g], mem_rd, mem_regwr, wb_rd, wb_regwr);
   end

   assign fwd_a = sel[0];
   assign fwd_b = sel[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: branch flush, load-use stall, mult/div
// freeze and EX forwarding. HAZARD_PERF_CNT_EN adds the stall_cycles counter.
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic [4:0]  ex_rs,
   input  logic [4:0]  ex_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem2reg,
   input  logic        ex_regwr,
   input  logic        ex_branch_taken,
   input  logic        ex_md_start,
   input  logic [4:0]  mem_rd,
   input  logic [4:0]  wb_rd,
   input  logic        mem_regwr,
   input  logic        wb_regwr,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_bubble,
   output logic        md_busy,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 2);

   state_t     state, state_n;
   logic [7:0] md_cnt, md_cnt_n;
   logic       load_use;

   assign load_use = ex_mem2reg && ex_regwr && ex_rd != REG_ZERO &&
                     ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= 8'd0;
      end else begin
         state  <= state_n;
         md_cnt <= md_cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      md_cnt_n    = md_cnt;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_bubble = 1'b0;
      md_busy     = 1'b0;
      // Everything held low while rst is high, regardless of inputs.
      if (!rst) begin
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_en     = 1'b1;
                  idex_bubble = 1'b1;
               end else if (load_use) begin
                  idex_en     = 1'b1;
                  idex_bubble = 1'b1;
               end else begin
                  pc_en   = 1'b1;
                  ifid_en = 1'b1;
                  idex_en = 1'b1;
               end
               if (ex_md_start) begin
                  state_n  = MD_WAIT;
                  md_cnt_n = MD_LOAD;
               end
            end
            MD_WAIT: begin
               md_busy = 1'b1;
               if (md_cnt == 8'd0) state_n = RUN;
               else                md_cnt_n = md_cnt - 8'd1;
            end
            default: state_n = RUN;
         endcase
      end
   end

   forward_unit u_fwd (
      .ex_rs     (ex_rs),
      .ex_rt     (ex_rt),
      .mem_rd    (mem_rd),
      .mem_regwr (mem_regwr),
      .wb_rd     (wb_rd),
      .wb_regwr  (wb_regwr),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b)
   );

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= 32'd0;
      else if (!pc_en && stall_cycles != 32'hFFFF_FFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model expectations,
// monitor pops and compares. Counter checks apply with HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

   localparam int MD = 4;

   typedef struct {
      logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, md_busy;
      logic [1:0]  fwd_a, fwd_b;
      logic [31:0] stall;
   } exp_t;

   logic       clk = 1'b0, rst = 1'b1;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic       id_use_rs, id_use_rt, ex_mem2reg, ex_regwr, ex_branch_taken, ex_md_start;
   logic       mem_regwr, wb_regwr;
   logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, md_busy;
   logic [1:0] fwd_a, fwd_b;
   logic [31:0] stall_cycles;

   exp_t q[$];
   int   checks = 0, failures = 0;
   int   frz = 0;            // remaining frozen cycles in the model
   logic [31:0] mcnt = 0;    // model stall-cycle count

   always #5 clk = ~clk;

   hazard_ctrl #(.MD_CYCLES(MD)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem2reg(ex_mem2reg),
      .ex_regwr(ex_regwr), .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_bubble(idex_bubble), .md_busy(md_busy), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );
`ifndef HAZARD_PERF_CNT_EN
   assign stall_cycles = 32'd0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fref(input logic [4:0] s);
      if (mem_regwr && mem_rd != 0 && mem_rd == s) return 2'b10;
      if (wb_regwr && wb_rd != 0 && wb_rd == s)    return 2'b01;
      return 2'b00;
   endfunction

   // Evaluate the rules for the inputs now applied, queue the result, advance model.
   task automatic push_expect();
      exp_t e;
      logic lu;
      e = '{default: '0};
      e.fwd_a = fref(ex_rs);
      e.fwd_b = fref(ex_rt);
      lu = ex_mem2reg && ex_regwr && ex_rd != 0 &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      if (rst) begin
         frz = 0; mcnt = 0;
      end else if (frz > 0) begin
         e.md_busy = 1;
      end else if (ex_branch_taken) begin
         {e.pc_en, e.ifid_en, e.ifid_flush, e.idex_en, e.idex_bubble} = 5'b11111;
      end else if (lu) begin
         {e.idex_en, e.idex_bubble} = 2'b11;
      end else begin
         {e.pc_en, e.ifid_en, e.idex_en} = 3'b111;
      end
      e.stall = mcnt;
      q.push_back(e);
      if (!rst) begin
         if (!e.pc_en && mcnt != 32'hFFFF_FFFF) mcnt++;
         if (frz > 0) frz--;
         else if (ex_md_start) frz = MD - 1;
      end
   endtask

   task automatic idle();
      {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
      {id_use_rs, id_use_rt, ex_mem2reg, ex_regwr, ex_branch_taken, ex_md_start} = '0;
      {mem_regwr, wb_regwr} = '0;
   endtask

   task automatic step();
      #1 push_expect();
      @(negedge clk);
   endtask

   task automatic set_load_use(input logic [4:0] r);
      ex_mem2reg = 1; ex_regwr = 1; ex_rd = r; id_rs = r; id_use_rs = 1;
   endtask

   task automatic rand_inputs();
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      ex_mem2reg = 1'($urandom); ex_regwr = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_md_start = ($urandom_range(0, 9) == 0);
      mem_regwr = 1'($urandom); wb_regwr = 1'($urandom);
   endtask

   // Monitor: outputs are presented every cycle; compare against queued expectations.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_en", 32'(pc_en), 32'(e.pc_en));
            check("ifid_en", 32'(ifid_en), 32'(e.ifid_en));
            check("ifid_flush", 32'(ifid_flush), 32'(e.ifid_flush));
            check("idex_en", 32'(idex_en), 32'(e.idex_en));
            check("idex_bubble", 32'(idex_bubble), 32'(e.idex_bubble));
            check("md_busy", 32'(md_busy), 32'(e.md_busy));
            check("fwd_a", 32'(fwd_a), 32'(e.fwd_a));
            check("fwd_b", 32'(fwd_b), 32'(e.fwd_b));
`ifdef HAZARD_PERF_CNT_EN
            check("stall_cycles", stall_cycles, e.stall);
`endif
         end
      end
   end

   initial begin
      idle();
      rst = 1;
      @(negedge clk);
      step();                                   // reset values
      rst = 0;
      step();                                   // plain RUN
      set_load_use(5'd8); step();               // load-use stall
      idle(); step();                           // bubble cleared it
      set_load_use(5'd0); mem_regwr = 1; mem_rd = 0; step();  // register 0
      idle(); set_load_use(5'd9); ex_branch_taken = 1; step(); // branch wins
      idle(); ex_md_start = 1; step();          // mult/div start
      idle(); ex_branch_taken = 1; ex_md_start = 1; set_load_use(5'd3);
      repeat (MD - 1) step();                   // frozen, inputs ignored
      idle(); step();                           // back in RUN
      ex_rs = 5; ex_rt = 5; mem_rd = 5; wb_rd = 5; mem_regwr = 1; wb_regwr = 1; step();
      mem_regwr = 0; step();
      ex_rt = 6; wb_rd = 6; step();
      idle(); ex_md_start = 1; step();
      idle(); step();                           // MD_WAIT cycle 1
      rst = 1; step();                          // abort in MD_WAIT cycle 2
      rst = 0; step();
      set_load_use(5'd4); step();               // one stall after reset
      idle(); step();
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         rst = ($urandom_range(0, 60) == 0);
         step();
      end
      rst = 0; idle();
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
